cordic_arbiter: RTL and testbench

Shares one pipelined `cordic` core between two independent requesters. Round-robin arbitration issues at most one operation per cycle into the core. A tag shift register matched to the core's fixed latency tracks ownership of each operation. Results return through per-requester FIFOs with ready/valid backpressure. The block sits directly in front of `cordic`, which has no valid or ready signals of its own.

---
 rtl/cordic_arbiter.sv | 110 +++++++++++
 tb/tb_cordic_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one fixed-latency cordic core between two requesters
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-low reset
//   reqN_valid/ready       request handshake (ready is combinational on valid)
//   reqN_mode/x/y/angle    operation mode and Q7.8 sign-magnitude operands
//   cdc_*                  operands to the cordic core, results back from it
//   rspN_valid/ready/a/b   first-word-fall-through result FIFO heads
//   busy                   any operation in flight or any result waiting
module cordic_arbiter #(
  parameter int LATENCY    = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_mode,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_angle,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_mode,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_angle,
  output logic        cdc_op_mode,
  output logic [15:0] cdc_x,
  output logic [15:0] cdc_y,
  output logic [15:0] cdc_angle,
  input  logic [15:0] cdc_x_or_phase,
  input  logic [15:0] cdc_y_or_size,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_a,
  output logic [15:0] rsp0_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_a,
  output logic [15:0] rsp1_b,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [1:0] valid, eligible, issue, push, pop, rsp_ready, nonempty, active;
  logic [31:0] head [2];
  logic [LATENCY-1:0] tag_v, tag_id;
  logic last, grant, winner;
  assign valid     = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  // On a tie the requester that did not win last time gets the core.
  assign grant  = |eligible;
  assign winner = &eligible ? ~last : eligible[1];
  assign issue  = {grant & winner, grant & ~winner};
  assign req0_ready = issue[0];
  assign req1_ready = issue[1];
  // Bubbles present all-zero operands so the core sees a defined input.
  assign cdc_op_mode = grant & (winner ? req1_mode : req0_mode);
  assign cdc_x       = !grant ? '0 : winner ? req1_x : req0_x;
  assign cdc_y       = !grant ? '0 : winner ? req1_y : req0_y;
  assign cdc_angle   = !grant ? '0 : winner ? req1_angle : req0_angle;
  // The tag tail lines up with the core output of the operation it describes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last   <= 1'b1;
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      if (grant) last <= winner;
      tag_v  <= {tag_v[LATENCY-2:0], grant};
      tag_id <= {tag_id[LATENCY-2:0], winner};
    end
  end
  genvar r;
  generate
    for (r = 0; r < 2; r++) begin : g_fifo
      logic [CW-1:0] count, inflight, credit;
      logic [AW-1:0] wr, rd;
      logic [31:0] mem [FIFO_DEPTH];
      // Credit reserves a FIFO slot for every operation already in the core.
      assign credit      = CW'(FIFO_DEPTH) - count - inflight;
      assign eligible[r] = valid[r] && credit != '0;
      assign push[r]     = tag_v[LATENCY-1] && tag_id[LATENCY-1] == 1'(r);
      assign nonempty[r] = count != '0;
      assign pop[r]      = nonempty[r] && rsp_ready[r];
      assign active[r]   = nonempty[r] || inflight != '0;
      assign head[r]     = nonempty[r] ? mem[rd] : '0;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wr       <= '0;
          rd       <= '0;
          count    <= '0;
          inflight <= '0;
        end else begin
          if (push[r]) wr <= wr + 1'b1;
          if (pop[r]) rd <= rd + 1'b1;
          count    <= count + CW'(push[r]) - CW'(pop[r]);
          inflight <= inflight + CW'(issue[r]) - CW'(push[r]);
        end
      end
      always_ff @(posedge clock)
        if (push[r]) mem[wr] <= {cdc_x_or_phase, cdc_y_or_size};
    end
  endgenerate
  assign rsp0_valid = nonempty[0];
  assign rsp1_valid = nonempty[1];
  assign {rsp0_a, rsp0_b} = head[0];
  assign {rsp1_a, rsp1_b} = head[1];
  assign busy = |active;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: scoreboard bench for cordic_arbiter with a fixed-latency stand-in core
module tb_cordic_arbiter;
  localparam int LAT = 10;
  logic clock, reset;
  logic req0_valid, req0_ready, req0_mode, req1_valid, req1_ready, req1_mode;
  logic [15:0] req0_x, req0_y, req0_angle, req1_x, req1_y, req1_angle;
  logic cdc_op_mode;
  logic [15:0] cdc_x, cdc_y, cdc_angle, cdc_x_or_phase, cdc_y_or_size;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
  logic [15:0] rsp0_a, rsp0_b, rsp1_a, rsp1_b;
  cordic_arbiter #(.LATENCY(LAT), .FIFO_DEPTH(16)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
    .req0_x(req0_x), .req0_y(req0_y), .req0_angle(req0_angle),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
    .req1_x(req1_x), .req1_y(req1_y), .req1_angle(req1_angle),
    .cdc_op_mode(cdc_op_mode), .cdc_x(cdc_x), .cdc_y(cdc_y), .cdc_angle(cdc_angle),
    .cdc_x_or_phase(cdc_x_or_phase), .cdc_y_or_size(cdc_y_or_size),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_a(rsp0_a), .rsp0_b(rsp0_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_a(rsp1_a), .rsp1_b(rsp1_b),
    .busy(busy));
  // Stand-in core: a distinctive reversible-ish mapping delayed by exactly LAT cycles.
  function automatic logic [31:0] core_fn(logic m, logic [15:0] x, logic [15:0] y, logic [15:0] a);
    return {x ^ a ^ {m, 15'h1234}, y + a + {15'h0, m}};
  endfunction
  logic [31:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= core_fn(cdc_op_mode, cdc_x, cdc_y, cdc_angle);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign {cdc_x_or_phase, cdc_y_or_size} = pipe[LAT-1];
  initial clock = 1'b0;
  always #5 clock = ~clock;
  int n_vec = 0, n_bad = 0;
  logic [31:0] q0 [$], q1 [$];
  logic v0, v1, m0, m1, p0, p1, g0, g1, rv0, rv1, bs;
  logic [15:0] x0, y0, a0, x1, y1, a1;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // One clock cycle: compare popped heads, apply inputs, record grants.
  task automatic step();
    logic [31:0] e;
    @(negedge clock);
    rv0 = rsp0_valid; rv1 = rsp1_valid; bs = busy;
    if (p0 && rv0) begin
      e = q0.size() != 0 ? q0.pop_front() : 32'hDEAD_BEEF;
      chk("rsp0_data", {32'h0, rsp0_a, rsp0_b}, {32'h0, e});
    end
    if (p1 && rv1) begin
      e = q1.size() != 0 ? q1.pop_front() : 32'hDEAD_BEEF;
      chk("rsp1_data", {32'h0, rsp1_a, rsp1_b}, {32'h0, e});
    end
    rsp0_ready = p0; rsp1_ready = p1;
    req0_valid = v0; req0_mode = m0; req0_x = x0; req0_y = y0; req0_angle = a0;
    req1_valid = v1; req1_mode = m1; req1_x = x1; req1_y = y1; req1_angle = a1;
    #1;
    g0 = req0_ready; g1 = req1_ready;
    chk("one_ready", {63'h0, g0 & g1}, 64'h0);
    if (g0) begin
      q0.push_back(core_fn(m0, x0, y0, a0));
      chk("cdc_req0", 64'({cdc_op_mode, cdc_x, cdc_y, cdc_angle}), 64'({m0, x0, y0, a0}));
    end else if (g1) begin
      q1.push_back(core_fn(m1, x1, y1, a1));
      chk("cdc_req1", 64'({cdc_op_mode, cdc_x, cdc_y, cdc_angle}), 64'({m1, x1, y1, a1}));
    end else
      chk("cdc_bubble", 64'({cdc_op_mode, cdc_x, cdc_y, cdc_angle}), 64'h0);
  endtask
  task automatic drain();
    int k = 0;
    v0 = 0; v1 = 0; p0 = 1; p1 = 1;
    do begin
      step();
      k++;
    end while ((bs || q0.size() != 0 || q1.size() != 0) && k < 80);
    chk("drain_bound", 64'(k < 80), 64'h1);
    chk("drain_empty", 64'(q0.size() + q1.size()), 64'h0);
  endtask
  task automatic rst_pulse();
    @(negedge clock);
    v0 = 0; v1 = 0; req0_valid = 0; req1_valid = 0; reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
    q0.delete(); q1.delete();
  endtask
  initial begin
    int n;
    reset = 0; v0 = 0; v1 = 0; m0 = 0; m1 = 0; p0 = 0; p1 = 0;
    x0 = 0; y0 = 0; a0 = 0; x1 = 0; y1 = 0; a1 = 0;
    req0_valid = 0; req1_valid = 0; req0_mode = 0; req1_mode = 0;
    req0_x = 0; req0_y = 0; req0_angle = 0; req1_x = 0; req1_y = 0; req1_angle = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clock); #1;
    chk("rst_outs", 64'({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready}), 64'h0);
    chk("rst_rsp", {rsp0_a, rsp0_b, rsp1_a, rsp1_b}, 64'h0);
    chk("rst_cdc", 64'({cdc_op_mode, cdc_x, cdc_y, cdc_angle}), 64'h0);
    @(negedge clock); reset = 1;
    // single rotate from req0, result exactly LAT+1 cycles later
    v0 = 1; x0 = 16'h0100; p0 = 1; p1 = 1;
    step();
    chk("single_ready", 64'(g0), 64'h1);
    v0 = 0;
    for (int i = 1; i <= LAT; i++) begin
      step();
      chk("single_early", 64'({rv0, rv1}), 64'h0);
      if (i == 1) chk("single_busy", 64'(bs), 64'h1);
    end
    step();
    chk("single_valid", 64'({rv0, rv1}), 64'h2);
    step();
    chk("single_idle", 64'({rv0, bs}), 64'h0);
    // round-robin from a fresh pointer: req0 takes the first tie
    rst_pulse();
    v0 = 1; v1 = 1;
    for (int i = 0; i < 8; i++) begin
      x0 = 16'(i); y0 = 16'(3 * i); a0 = 16'h0010; x1 = 16'(16'h0200 + i); y1 = 16'(i); a1 = 16'h0020;
      step();
      chk("rr_grant", 64'({g0, g1}), (i % 2 == 0) ? 64'h2 : 64'h1);
    end
    drain();
    // credit stall with no pops
    rst_pulse();
    v0 = 1; p0 = 0; n = 0;
    for (int i = 0; i < 20; i++) begin
      x0 = 16'(16'h0300 + i); y0 = 16'(i); a0 = 16'(7 * i);
      step();
      if (g0) n++;
    end
    chk("stall_issues", 64'(n), 64'd16);
    chk("stall_ready", 64'(g0), 64'h0);
    p0 = 1; x0 = 16'h0777;
    step();
    chk("stall_pop_cycle", 64'(g0), 64'h0);
    p0 = 0;
    step();
    chk("stall_refill", 64'(g0), 64'h1);
    x0 = 16'h0888;
    step();
    chk("stall_again", 64'(g0), 64'h0);
    drain();
    // mixed modes: one phase op on req1 amid req0 rotates
    v0 = 1; m0 = 0;
    for (int i = 0; i < 6; i++) begin
      x0 = 16'(16'h0040 * i); y0 = 16'(16'h8000 | i); a0 = 16'(16'h0100 + i);
      v1 = (i == 2); m1 = 1; x1 = 16'h0100; y1 = 16'h0100; a1 = 0;
      step();
      if (i == 2) chk("mixed_grant1", 64'({g0, g1}), 64'h1);
    end
    m1 = 0;
    drain();
    // push and pop on FIFO 0 in the same cycle with one entry held
    p0 = 0; v0 = 1; x0 = 16'h0A0A; y0 = 16'h0101; a0 = 16'h0003;
    step();
    x0 = 16'h0B0B; y0 = 16'h0202; a0 = 16'h0004;
    step();
    v0 = 0;
    repeat (LAT - 1) step();
    p0 = 1;
    step();
    chk("sim_first", 64'(rv0), 64'h1);
    step();
    chk("sim_second", 64'(rv0), 64'h1);
    step();
    chk("sim_empty", 64'({rv0, bs}), 64'h0);
    // reset with operations outstanding
    v0 = 1;
    for (int i = 0; i < 5; i++) begin
      x0 = 16'(16'h0500 + i);
      step();
    end
    v0 = 0;
    @(negedge clock);
    req0_valid = 0; reset = 0;
    #1;
    chk("midrst_outs", 64'({rsp0_valid, rsp1_valid, busy, req0_ready, req1_ready}), 64'h0);
    chk("midrst_cdc", 64'({cdc_op_mode, cdc_x, cdc_y, cdc_angle}), 64'h0);
    repeat (2) @(negedge clock);
    reset = 1;
    q0.delete(); q1.delete();
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("midrst_stale", 64'({rv0, rv1, bs}), 64'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
